// File: rtl/ext_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : ext_alu_core
// Description : Multi-cycle MMIO ALU engine with an OP1/OP2/result handshake,
//               iterative multiply/divide and a write-protected result register.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_alu_core #(
    parameter int DBITS    = 32,
    parameter int OPBITS   = 4,
    parameter int FAST_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DBITS-1:0]  OP1,
    input  logic [DBITS-1:0]  OP2,
    input  logic [OPBITS-1:0] ALUOP,
    input  logic [2:0]        CSR_ALU_IN,
    output logic [DBITS-1:0]  OP3,
    output logic [2:0]        CSR_ALU_OUT
);

    localparam int SHW     = $clog2(DBITS);
    localparam int CNT_MAX = (DBITS > FAST_LAT) ? DBITS : FAST_LAT;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] c_iter_cnt = CW'(DBITS - 1);
    localparam logic [CW-1:0] c_fast_cnt = CW'(FAST_LAT - 1);

    localparam logic [2:0] c_s_op1  = 3'd0;
    localparam logic [2:0] c_s_op2  = 3'd1;
    localparam logic [2:0] c_s_exec = 3'd2;
    localparam logic [2:0] c_s_wb   = 3'd3;
    localparam logic [2:0] c_s_done = 3'd4;

    localparam logic [OPBITS-1:0] c_op_add   = OPBITS'(0);
    localparam logic [OPBITS-1:0] c_op_sub   = OPBITS'(1);
    localparam logic [OPBITS-1:0] c_op_and   = OPBITS'(2);
    localparam logic [OPBITS-1:0] c_op_or    = OPBITS'(3);
    localparam logic [OPBITS-1:0] c_op_xor   = OPBITS'(4);
    localparam logic [OPBITS-1:0] c_op_sll   = OPBITS'(5);
    localparam logic [OPBITS-1:0] c_op_srl   = OPBITS'(6);
    localparam logic [OPBITS-1:0] c_op_sra   = OPBITS'(7);
    localparam logic [OPBITS-1:0] c_op_slt   = OPBITS'(8);
    localparam logic [OPBITS-1:0] c_op_sltu  = OPBITS'(9);
    localparam logic [OPBITS-1:0] c_op_mul   = OPBITS'(10);
    localparam logic [OPBITS-1:0] c_op_mulhu = OPBITS'(11);
    localparam logic [OPBITS-1:0] c_op_divu  = OPBITS'(12);
    localparam logic [OPBITS-1:0] c_op_remu  = OPBITS'(13);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [2:0]        w_csr_nxt;
    logic [DBITS-1:0]  r_op1;
    logic [DBITS-1:0]  r_op2;
    logic [OPBITS-1:0] r_aluop;
    logic [CW-1:0]     r_cnt;
    logic [DBITS-1:0]  r_hi;
    logic [DBITS-1:0]  r_lo;
    logic [DBITS-1:0]  w_hi_nxt;
    logic [DBITS-1:0]  w_lo_nxt;
    logic [DBITS:0]    w_mul_sum;
    logic [DBITS:0]    w_div_trial;
    logic [DBITS-1:0]  w_result;
    logic [SHW-1:0]    w_shamt;
    logic              w_op1_hs;
    logic              w_op2_hs;
    logic              w_is_iter;
    logic              w_is_div;

    assign w_op1_hs  = CSR_ALU_IN[1] & CSR_ALU_OUT[0];
    assign w_op2_hs  = CSR_ALU_IN[2] & CSR_ALU_OUT[1];
    assign w_is_iter = (r_aluop == c_op_mul) || (r_aluop == c_op_mulhu) ||
                       (r_aluop == c_op_divu) || (r_aluop == c_op_remu);
    assign w_is_div  = (r_aluop == c_op_divu) || (r_aluop == c_op_remu);
    assign w_shamt   = r_op2[SHW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_op1:  if (w_op1_hs)        w_state_nxt = c_s_op2;
            c_s_op2:  if (w_op2_hs)        w_state_nxt = c_s_exec;
            c_s_exec: if (r_cnt == '0)     w_state_nxt = c_s_wb;
            c_s_wb:   if (!CSR_ALU_IN[0])  w_state_nxt = c_s_done;
            c_s_done: if (w_op1_hs)        w_state_nxt = c_s_op2;
            default:                       w_state_nxt = c_s_op1;
        endcase
    end

    always_comb begin
        w_csr_nxt = 3'b000;
        case (w_state_nxt)
            c_s_op1:  w_csr_nxt = 3'b001;
            c_s_op2:  w_csr_nxt = 3'b010;
            c_s_done: w_csr_nxt = 3'b101;
            default:  w_csr_nxt = 3'b000;
        endcase
    end

    // {r_hi, r_lo} is the product register for multiply (multiplier in r_lo,
    // shifted out LSB first) and the remainder/quotient pair for restoring divide.
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op1} : {(DBITS+1){1'b0}});
        w_div_trial = {r_hi, r_lo[DBITS-1]} - {1'b0, r_op2};
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        if (w_is_div) begin
            if (!w_div_trial[DBITS]) begin
                w_hi_nxt = w_div_trial[DBITS-1:0];
                w_lo_nxt = {r_lo[DBITS-2:0], 1'b1};
            end else begin
                w_hi_nxt = {r_hi[DBITS-2:0], r_lo[DBITS-1]};
                w_lo_nxt = {r_lo[DBITS-2:0], 1'b0};
            end
        end else begin
            w_hi_nxt = w_mul_sum[DBITS:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[DBITS-1:1]};
        end
    end

    always_comb begin
        w_result = '0;
        case (r_aluop)
            c_op_add:   w_result = r_op1 + r_op2;
            c_op_sub:   w_result = r_op1 - r_op2;
            c_op_and:   w_result = r_op1 & r_op2;
            c_op_or:    w_result = r_op1 | r_op2;
            c_op_xor:   w_result = r_op1 ^ r_op2;
            c_op_sll:   w_result = r_op1 << w_shamt;
            c_op_srl:   w_result = r_op1 >> w_shamt;
            c_op_sra:   w_result = $signed(r_op1) >>> w_shamt;
            c_op_slt:   w_result = {{(DBITS-1){1'b0}}, ($signed(r_op1) < $signed(r_op2))};
            c_op_sltu:  w_result = {{(DBITS-1){1'b0}}, (r_op1 < r_op2)};
            c_op_mul:   w_result = r_lo;
            c_op_mulhu: w_result = r_hi;
            c_op_divu:  w_result = r_lo;
            c_op_remu:  w_result = r_hi;
            default:    w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_s_op1;
            CSR_ALU_OUT <= 3'b001;
            OP3         <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_aluop     <= '0;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            CSR_ALU_OUT <= w_csr_nxt;
            if (w_op1_hs) begin
                r_op1   <= OP1;
                r_aluop <= ALUOP;
            end
            // r_op1 already holds the dividend when OP2 arrives.
            if (w_op2_hs) begin
                r_op2 <= OP2;
                r_cnt <= w_is_iter ? c_iter_cnt : c_fast_cnt;
                r_hi  <= '0;
                r_lo  <= w_is_div ? r_op1 : OP2;
            end
            if (r_state == c_s_exec) begin
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                if (w_is_iter) begin
                    r_hi <= w_hi_nxt;
                    r_lo <= w_lo_nxt;
                end
            end
            if ((r_state == c_s_wb) && !CSR_ALU_IN[0]) OP3 <= w_result;
        end
    end

endmodule
`default_nettype wire

// File: doc/ext_alu_core.md
Name: ext_alu_core

Overview:
Multi-cycle MMIO ALU engine directly downstream of the FU stage. It consumes the OP1/OP2/ALUOP registers and the 3-bit CSR_ALU_IN handshake that the FU stage drives, and returns OP3 and CSR_ALU_OUT. Single-cycle ops complete after FAST_LAT cycles. MUL/MULHU/DIVU/REMU run iteratively, one bit per cycle. The result register is write-protected under control of CSR_ALU_IN[0].

Parameters:
DBITS, 32, operand/result width (ALUDATABITS)
OPBITS, 4, ALUOP width
FAST_LAT, 1, execute cycles for non-iterative ops (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
OP1  input  DBITS  operand 1, sampled on OP1 handshake
OP2  input  DBITS  operand 2, sampled on OP2 handshake
ALUOP  input  OPBITS  opcode, sampled together with OP1
CSR_ALU_IN  input  3  [0] result protect (1 = OP3 must not change); [1] OP1 stable; [2] OP2 stable
OP3  output  DBITS  result register
CSR_ALU_OUT  output  3  [0] OP1 port ready; [1] OP2 port ready; [2] result valid

Behaviour:
- Reset (synchronous, active-high; clk): state=S_OP1, OP3=0, CSR_ALU_OUT=3'b001, iteration counter=0, internal operand latches=0. Reset mid-operation abandons the operation with no partial OP3 write.
- All outputs are registered. Handshake sampling happens on the rising edge where the stable bit is 1 and the matching ready bit is 1.
- State S_OP1, outputs 3'b001:
  - On CSR_ALU_IN[1] & ready[0]: latch OP1 and ALUOP, go to S_OP2.
  - CSR_ALU_IN[2] is ignored in this state.
- State S_OP2, outputs 3'b010:
  - On CSR_ALU_IN[2] & ready[1]: latch OP2, load counter, go to S_EXEC.
  - CSR_ALU_IN[1] is ignored (no OP1 re-latch).
- State S_EXEC, outputs 3'b000:
  - Fast ops: counter=FAST_LAT-1, decrement each cycle, finish at 0.
  - Iterative ops: counter=DBITS-1, one shift-add or restoring-divide step per cycle, finish after DBITS cycles.
  - On finish, go to S_WB.
- State S_WB, outputs 3'b000:
  - If CSR_ALU_IN[0]==0: write OP3=result, go to S_DONE.
  - Otherwise hold indefinitely with OP3 unchanged.
- State S_DONE, outputs 3'b101 (result valid + OP1 ready):
  - OP3 is stable.
  - On an OP1 handshake: latch OP1/ALUOP, clear valid, go to S_OP2.
  - CSR_ALU_IN[0] toggling here has no effect; OP3 is written only in S_WB.
- ALUOP encoding (shift amount = OP2[4:0]; signed ops are two's complement):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA
  - 8 SLT (signed, 0/1), 9 SLTU (0/1)
  - 10 MUL (low 32 bits), 11 MULHU (high 32 bits, unsigned), 12 DIVU, 13 REMU
  - 14-15 reserved: fast path, result 0
- Arithmetic: ADD/SUB wrap modulo 2^32; no overflow flag.
- Divide by zero (OP2==0):
  - DIVU result=32'hFFFF_FFFF; REMU result=OP1.
  - Still takes the full DBITS cycles.
- Latency from OP2 sample edge to result-valid with protect low: FAST_LAT+1 cycles for fast ops, DBITS+1 cycles for iterative ops.
- Simultaneous CSR_ALU_IN[1] and [2] in S_OP1: only OP1 is accepted. OP2 requires a later pulse while in S_OP2.
- A stable pulse held for more than one cycle causes only one latch, because ready drops after the sampling edge.

Test Plan:
- Reset, then idle 5 cycles -> CSR_ALU_OUT=3'b001, OP3=0 throughout.
- ALUOP=0, OP1=32'h7FFF_FFFF, OP2=1, handshake both, protect=0 -> valid FAST_LAT+1 cycles after OP2 edge, OP3=32'h8000_0000; ALUOP=7 with OP1=32'h8000_0000, OP2=4 -> OP3=32'hF800_0000.
- MUL OP1=32'h0001_0000, OP2=32'h0003_0000 -> OP3=0 after 33 cycles; MULHU with the same operands -> OP3=32'h0000_0003.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU with OP2=0 -> 32'hFFFF_FFFF; REMU with OP2=0 -> 100. Each must take exactly DBITS cycles in S_EXEC.
- Hold protect=1 through execution of ADD 1+2 with OP3 previously 32'hDEAD_BEEF:
  - OP3 stays DEAD_BEEF and valid stays 0 while protect=1.
  - Drop protect -> next edge OP3=3, valid=1.
- Assert reset in cycle 10 of a DIVU -> next edge CSR_ALU_OUT=3'b001, OP3=0; a following ADD completes normally. Pulse OP1+OP2 stable together in S_OP1 -> only OP1 latched, state S_OP2.
